// File: rtl/fp_acc_pkg.sv
// Shared FSM state encoding and FP16 constants for the FP16 burst accumulator.
package fp_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } acc_state_e;

  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
  localparam logic [14:0] FP16_MAX_FIN = 15'h7BFF;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

endpackage

// File: rtl/fp16_sat.sv
// Overflow detect and optional clamp of the external adder result.
// Clamp to signed max finite is enabled by defining FP_ACC_SAT_EN.
module fp16_sat
  import fp_acc_pkg::*;
(
  input  logic [15:0] i_res,
  output logic [15:0] o_res,
  output logic        o_ovf
);

  always_comb begin
    o_ovf = (i_res[14:10] == FP16_EXP_MAX);
`ifdef FP_ACC_SAT_EN
    o_res = o_ovf ? {i_res[15], FP16_MAX_FIN} : i_res;
`else
    o_res = i_res;
`endif
  end

endmodule

// File: rtl/fp16_acc_seq.sv
// Sequencer summing a burst of i_len FP16 samples through an external combinational adder.
// Optional saturation on overflow via FP_ACC_SAT_EN (see fp16_sat).
module fp16_acc_seq
  import fp_acc_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [15:0]      i_data,
  output logic [15:0]      o_add_a,
  output logic [15:0]      o_add_b,
  input  logic [15:0]      i_add_res,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [15:0]      o_data,
  output logic             o_busy,
  output logic [LEN_W-1:0] o_cnt,
  output logic             o_ovf
);

  acc_state_e       state_q;
  logic [15:0]      acc_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             valid_q, ovf_q;
  logic [15:0]      sum_sat;
  logic             sum_ovf;
  logic             last;

  fp16_sat u_sat (
    .i_res (i_add_res),
    .o_res (sum_sat),
    .o_ovf (sum_ovf)
  );

  always_comb begin
    cnt_d = cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
    last  = (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1});
  end

  assign o_ready = (state_q == LOAD) || (state_q == ACC);
  assign o_add_a = acc_q;
  assign o_add_b = i_data;
  assign o_valid = valid_q;
  assign o_data  = acc_q;
  assign o_busy  = (state_q != IDLE);
  assign o_cnt   = cnt_q;
  assign o_ovf   = ovf_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= FP16_ZERO;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            ovf_q <= 1'b0;
            if (i_len == '0) begin
              acc_q   <= FP16_ZERO;
              cnt_q   <= '0;
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q   <= i_len;
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          // First sample is loaded raw: the adder cannot handle a zero seed.
          if (i_valid) begin
            acc_q <= i_data;
            cnt_q <= cnt_d;
            if (last) begin
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (i_valid) begin
            acc_q <= sum_sat;
            cnt_q <= cnt_d;
            if (sum_ovf) ovf_q <= 1'b1;
            if (last) begin
              valid_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
